// File: rtl/novacore_cfg_loader.sv
// novacore_cfg_loader: loads (uid, word) pairs into the NovaCORE fabric config port.
// Ports: clk/rst, start, in_* valid/ready word stream, c_bus/c_uid/c_clk/mode to fabric, busy/done/err_*/loaded status.
module novacore_cfg_loader #(
  parameter int BUS_W   = 82,
  parameter int UID_W   = 9,
  parameter int N_UNITS = 100,
  parameter int SETUP   = 1,
  parameter int CLK_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BUS_W-1:0] in_data,
  input  logic [UID_W-1:0] in_uid,
  input  logic             in_last,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             mode,
  output logic [BUS_W-1:0] c_bus,
  output logic [UID_W-1:0] c_uid,
  output logic             c_clk,
  output logic             busy,
  output logic             done,
  output logic             err_uid,
  output logic             err_dup,
  output logic             err_count,
  output logic [UID_W:0]   loaded
);

  localparam int CMAX  = (SETUP > CLK_DIV) ? SETUP : CLK_DIV;
  localparam int CNT_W = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int IDX_W = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;

  localparam logic [UID_W:0]   N_LD   = (UID_W+1)'(N_UNITS);
  localparam logic [UID_W:0]   LD_ONE = (UID_W+1)'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] SU_END = CNT_W'(SETUP - 1);
  localparam logic [CNT_W-1:0] DV_END = CNT_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_FINISH
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             last_q;
  logic [N_UNITS-1:0] bitmap;
  logic             uid_ok;
  logic [IDX_W-1:0] idx;

  assign uid_ok = ({1'b0, in_uid} < N_LD);
  // c_uid only ever holds an in-range uid, so its low bits index the bitmap
  assign idx    = c_uid[IDX_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    in_ready = 1'b0;
    mode     = 1'b0;
    busy     = 1'b0;
    c_clk    = 1'b0;
    done     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) state_nx = S_WAIT;
      end
      S_WAIT: begin
        in_ready = 1'b1;
        mode     = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          if (uid_ok) begin
            state_nx = S_SETUP;
            cnt_nx   = '0;
          end else if (in_last) begin
            state_nx = S_FINISH;
          end
        end
      end
      S_SETUP: begin
        mode = 1'b1;
        busy = 1'b1;
        if (cnt == SU_END) begin
          state_nx = S_HIGH;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      S_HIGH: begin
        mode  = 1'b1;
        busy  = 1'b1;
        c_clk = 1'b1;
        if (cnt == DV_END) begin
          state_nx = S_LOW;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      S_LOW: begin
        mode = 1'b1;
        busy = 1'b1;
        if (cnt == DV_END) begin
          state_nx = last_q ? S_FINISH : S_WAIT;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      S_FINISH: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_bus     <= '0;
      c_uid     <= '0;
      last_q    <= 1'b0;
      bitmap    <= '0;
      loaded    <= '0;
      err_uid   <= 1'b0;
      err_dup   <= 1'b0;
      err_count <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        bitmap    <= '0;
        loaded    <= '0;
        err_uid   <= 1'b0;
        err_dup   <= 1'b0;
        err_count <= 1'b0;
      end
      if (state == S_WAIT && in_valid) begin
        if (uid_ok) begin
          c_bus  <= in_data;
          c_uid  <= in_uid;
          last_q <= in_last;
        end else begin
          err_uid <= 1'b1;
        end
      end
      // bookkeeping happens as the strobe rises
      if (state == S_SETUP && state_nx == S_HIGH) begin
        if (bitmap[idx]) begin
          err_dup <= 1'b1;
        end else begin
          bitmap[idx] <= 1'b1;
          if (loaded != N_LD) loaded <= loaded + LD_ONE;
        end
      end
      // loaded is final on every path into FINISH
      if (state_nx == S_FINISH) begin
        err_count <= (loaded != N_LD);
      end
    end
  end

endmodule

// File: tb/tb_novacore_cfg_loader.sv
// tb_novacore_cfg_loader: scoreboard bench for novacore_cfg_loader.
// Driver pushes expected strobes/session results; monitor pops on c_clk rise and done.
module tb_novacore_cfg_loader;

  localparam int BUS_W   = 82;
  localparam int UID_W   = 9;
  localparam int N       = 100;
  localparam int SETUP   = 1;
  localparam int CLK_DIV = 2;
  localparam int SPACING = 1 + SETUP + 2 * CLK_DIV;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [BUS_W-1:0] in_data = '0;
  logic [UID_W-1:0] in_uid = '0;
  logic             in_last = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             mode;
  logic [BUS_W-1:0] c_bus;
  logic [UID_W-1:0] c_uid;
  logic             c_clk;
  logic             busy;
  logic             done;
  logic             err_uid;
  logic             err_dup;
  logic             err_count;
  logic [UID_W:0]   loaded;

  novacore_cfg_loader #(
    .BUS_W(BUS_W), .UID_W(UID_W), .N_UNITS(N),
    .SETUP(SETUP), .CLK_DIV(CLK_DIV)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_data(in_data), .in_uid(in_uid),
    .in_last(in_last), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode),
    .c_bus(c_bus), .c_uid(c_uid), .c_clk(c_clk),
    .busy(busy), .done(done),
    .err_uid(err_uid), .err_dup(err_dup),
    .err_count(err_count), .loaded(loaded)
  );

  typedef struct {
    int uid;
    logic [BUS_W-1:0] d;
  } pulse_t;

  typedef struct {
    int loaded;
    bit eu;
    bit ed;
    bit ec;
    int pulses;
    bit lastgood;
  } sess_t;

  pulse_t pq[$];
  sess_t  sq[$];
  sess_t  prev_exp;
  bit     have_prev = 0;
  int     checks = 0;
  int     failures = 0;
  int     cyc = 0;
  int     last_acc_cyc = 0;
  bit     have_acc = 0;
  logic [BUS_W-1:0] last_good = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [BUS_W-1:0] act,
                     input logic [BUS_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [BUS_W-1:0] rnd_data();
    return {18'($urandom()), $urandom(), $urandom()};
  endfunction

  // monitor: strobe contents, strobe stability, end-of-session status
  initial begin : mon
    bit prev = 0;
    int pc = 0;
    int rise_cyc = 0;
    logic [BUS_W-1:0] hb = '0;
    logic [UID_W-1:0] hu = '0;
    pulse_t p;
    sess_t  s;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 0;
        pc = 0;
      end else begin
        if (c_clk && !prev) begin
          pc++;
          rise_cyc = cyc;
          if (pq.size() == 0) begin
            chk("pulse_unexpected", 1, 0);
          end else begin
            p = pq.pop_front();
            chk("pulse_uid", BUS_W'(c_uid), BUS_W'(p.uid));
            chk("pulse_bus", c_bus, p.d);
          end
          chk("pulse_mode", BUS_W'(mode), 1);
          hb = c_bus;
          hu = c_uid;
        end else if (c_clk) begin
          chk("bus_stable", c_bus, hb);
          chk("uid_stable", BUS_W'(c_uid), BUS_W'(hu));
        end
        prev = c_clk;
        if (done) begin
          if (sq.size() == 0) begin
            chk("done_unexpected", 1, 0);
          end else begin
            s = sq.pop_front();
            chk("loaded", BUS_W'(loaded), BUS_W'(s.loaded));
            chk("err_uid", BUS_W'(err_uid), BUS_W'(s.eu));
            chk("err_dup", BUS_W'(err_dup), BUS_W'(s.ed));
            chk("err_count", BUS_W'(err_count), BUS_W'(s.ec));
            chk("pulse_count", BUS_W'(pc), BUS_W'(s.pulses));
            chk("done_mode", BUS_W'(mode), 0);
            if (s.lastgood)
              chk("done_delay", BUS_W'(cyc - rise_cyc), BUS_W'(2 * CLK_DIV));
          end
          pc = 0;
        end
      end
    end
  end

  task automatic send_word(input int uid, input logic [BUS_W-1:0] d,
                           input bit last, input int gap, input bit noise,
                           input bit spc);
    int g;
    int n;
    bit acc;
    pulse_t p;
    g = (gap > 0) ? $urandom_range(gap, 0) : 0;
    for (int i = 0; i < g; i++) begin
      in_valid = 1'b0;
      start = noise && ($urandom_range(1, 0) == 1);
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    in_valid = 1'b1;
    in_uid = UID_W'(uid);
    in_data = d;
    in_last = last;
    acc = 0;
    n = 0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) begin
        if (uid < N) begin
          p.uid = uid;
          p.d = d;
          pq.push_back(p);
          if (spc && have_acc)
            chk("acc_spacing", BUS_W'(cyc - last_acc_cyc), BUS_W'(SPACING));
          have_acc = 1;
          last_acc_cyc = cyc;
          last_good = d;
        end else begin
          have_acc = 0;
        end
      end
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    if (!acc) chk("accept_timeout", 0, 1);
    if (acc && uid >= N && !last) begin
      chk("bad_ready", BUS_W'(in_ready), 1);
      chk("bad_noclk", BUS_W'(c_clk), 0);
      chk("bad_bus_hold", c_bus, last_good);
    end
  endtask

  task automatic do_start();
    in_valid = 1'b1;
    in_uid = UID_W'(3);
    in_data = rnd_data();
    in_last = 1'b0;
    @(negedge clk);
    chk("idle_ready", BUS_W'(in_ready), 0);
    chk("idle_mode", BUS_W'(mode), 0);
    if (have_prev) begin
      chk("hold_loaded", BUS_W'(loaded), BUS_W'(prev_exp.loaded));
      chk("hold_err_uid", BUS_W'(err_uid), BUS_W'(prev_exp.eu));
      chk("hold_err_dup", BUS_W'(err_dup), BUS_W'(prev_exp.ed));
      chk("hold_err_count", BUS_W'(err_count), BUS_W'(prev_exp.ec));
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("start_busy", BUS_W'(busy), 1);
    chk("start_mode", BUS_W'(mode), 1);
    chk("start_ready", BUS_W'(in_ready), 1);
    chk("start_loaded", BUS_W'(loaded), 0);
    chk("start_flags", BUS_W'({err_uid, err_dup, err_count}), 0);
  endtask

  task automatic run_session(input int q[$], input int gap, input bit noise,
                             input bit spc);
    sess_t e;
    bit seen[int];
    int distinct;
    int w;
    distinct = 0;
    e.pulses = 0;
    e.eu = 0;
    e.ed = 0;
    foreach (q[i]) begin
      if (q[i] >= N) begin
        e.eu = 1;
      end else begin
        e.pulses++;
        if (seen.exists(q[i])) e.ed = 1;
        else begin
          seen[q[i]] = 1;
          distinct++;
        end
      end
    end
    e.loaded = (distinct > N) ? N : distinct;
    e.ec = (e.loaded != N);
    e.lastgood = (q[q.size()-1] < N);
    do_start();
    sq.push_back(e);
    prev_exp = e;
    have_prev = 1;
    have_acc = 0;
    foreach (q[i])
      send_word(q[i], rnd_data(), i == q.size() - 1, gap, noise, spc);
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!done && w < 60);
    chk("done_seen", BUS_W'(done), 1);
    @(posedge clk);
    #1;
    chk("busy_after", BUS_W'(busy), 0);
  endtask

  initial begin : drv
    int q[$];
    int w;
    int dpos;
    int bpos;
    int perm[N];
    int j;
    int t;
    repeat (2) @(negedge clk);
    chk("rst_busy", BUS_W'(busy), 0);
    chk("rst_mode", BUS_W'(mode), 0);
    chk("rst_cclk", BUS_W'(c_clk), 0);
    chk("rst_ready", BUS_W'(in_ready), 0);
    chk("rst_done", BUS_W'(done), 0);
    chk("rst_loaded", BUS_W'(loaded), 0);
    chk("rst_bus", c_bus, 0);
    chk("rst_flags", BUS_W'({err_uid, err_dup, err_count}), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    q.delete();
    for (int i = 0; i < N; i++) q.push_back(i);
    run_session(q, 0, 0, 1);

    q.delete();
    for (int i = 0; i < N; i++) begin
      if (i == 50) q.push_back(100);
      q.push_back(i);
    end
    run_session(q, 0, 0, 0);

    q.delete();
    for (int i = 0; i < N; i++) begin
      q.push_back(i);
      if (i == 60) q.push_back(5);
    end
    run_session(q, 0, 0, 1);

    q.delete();
    for (int i = 0; i < N - 1; i++) q.push_back(i);
    run_session(q, 0, 0, 1);

    do_start();
    have_acc = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 20) send_word(100, rnd_data(), 0, 0, 0, 0);
      send_word(i, rnd_data(), 0, 0, 0, 0);
    end
    send_word(40, rnd_data(), 0, 0, 0, 0);
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!c_clk && w < 20);
    chk("t5_high", BUS_W'(c_clk), 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("t5_cclk", BUS_W'(c_clk), 0);
    chk("t5_mode", BUS_W'(mode), 0);
    chk("t5_busy", BUS_W'(busy), 0);
    chk("t5_ready", BUS_W'(in_ready), 0);
    chk("t5_err_uid", BUS_W'(err_uid), 0);
    chk("t5_loaded", BUS_W'(loaded), 0);
    chk("t5_pq_empty", BUS_W'(pq.size()), 0);
    pq.delete();
    last_good = '0;
    have_prev = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < N; i++) perm[i] = i;
      for (int i = N - 1; i > 0; i--) begin
        j = $urandom_range(i, 0);
        t = perm[i];
        perm[i] = perm[j];
        perm[j] = t;
      end
      dpos = $urandom_range(N - 2, 10);
      bpos = $urandom_range(N - 2, 0);
      q.delete();
      for (int i = 0; i < N; i++) begin
        q.push_back(perm[i]);
        if (i == dpos && s == 0) q.push_back(perm[$urandom_range(dpos, 0)]);
        if (i == bpos) q.push_back($urandom_range(511, 100));
      end
      run_session(q, 3, 1, 0);
    end

    repeat (5) @(posedge clk);
    chk("end_pq_empty", BUS_W'(pq.size()), 0);
    chk("end_sq_empty", BUS_W'(sq.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
